// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol geometry, control tokens and the alignment
// FSM encoding used by the receive deserializer, encoder and decoder.
package tmds_pkg;

    localparam int SYM_W    = 10;
    localparam int HIST_W   = 2 * SYM_W;
    localparam int OFFSET_W = 4;
    localparam int PHASE_W  = 3;

    localparam logic [PHASE_W-1:0]  PHASE_LAST = 3'd4;
    localparam logic [OFFSET_W-1:0] OFFSET_MAX = 4'(SYM_W - 1);

    localparam logic [SYM_W-1:0] CTRL_TOKEN_0 = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_1 = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_2 = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_3 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } align_state_e;

    // Bit-slip advances the window by one bit and wraps after the last offset.
    function automatic logic [OFFSET_W-1:0] next_offset(input logic [OFFSET_W-1:0] off);
        return (off == OFFSET_MAX) ? '0 : off + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_token_det.sv
// Combinational TMDS control-token detector: flags any of the four
// control-period symbols.
module tmds_token_det
    import tmds_pkg::*;
(
    input  logic [SYM_W-1:0] i_sym,
    output logic             o_is_token
);

    always_comb begin
        o_is_token = (i_sym == CTRL_TOKEN_0) || (i_sym == CTRL_TOKEN_1) ||
                     (i_sym == CTRL_TOKEN_2) || (i_sym == CTRL_TOKEN_3);
    end

endmodule

// File: rtl/tmds_ser2par.sv
// TMDS receive deserializer: assembles 10-bit symbols from a two-bit-per-cycle
// stream and bit-slips until control tokens establish symbol alignment.
module tmds_ser2par
    import tmds_pkg::*;
#(
    parameter int SEARCH_WORDS = 64,
    parameter int LOCK_TOKENS  = 4,
    parameter int LOSS_WORDS   = 4096
) (
    input  logic                clk_5x,
    input  logic                rst,
    input  logic [1:0]          i_ser_data,
    output logic [SYM_W-1:0]    o_par_data,
    output logic                o_par_valid,
    output logic                o_locked,
    output logic [OFFSET_W-1:0] o_slip_cnt
);

    localparam int WC_W = $clog2(SEARCH_WORDS + 1);
    localparam int TC_W = $clog2(LOCK_TOKENS + 1);
    localparam int LC_W = $clog2(LOSS_WORDS + 1);

    logic [HIST_W-1:0]   hist_q,      hist_d;
    logic [PHASE_W-1:0]  phase_q,     phase_d;
    logic [OFFSET_W-1:0] offset_q,    offset_d;
    align_state_e        state_q,     state_d;
    logic [WC_W-1:0]     word_cnt_q,  word_cnt_d;
    logic [TC_W-1:0]     tok_cnt_q,   tok_cnt_d;
    logic [LC_W-1:0]     loss_cnt_q,  loss_cnt_d;
    logic [SYM_W-1:0]    par_data_q,  par_data_d;
    logic                par_valid_q, par_valid_d;
    logic                locked_q,    locked_d;

    logic [SYM_W-1:0]    word;
    logic                is_token;
    logic                extract;

    tmds_token_det u_token_det (
        .i_sym      (word),
        .o_is_token (is_token)
    );

    // Newest pair enters at the top, so time runs upward through hist_q.
    always_comb begin
        hist_d  = {i_ser_data[1], i_ser_data[0], hist_q[HIST_W-1:2]};
        phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 3'd1;
        extract = (phase_q == PHASE_LAST);
        word    = '0;
        for (int i = 0; i < SYM_W; i++) begin
            if (offset_q == OFFSET_W'(i)) begin
                word = hist_q[i +: SYM_W];
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        word_cnt_d  = word_cnt_q;
        tok_cnt_d   = tok_cnt_q;
        loss_cnt_d  = loss_cnt_q;
        par_data_d  = par_data_q;
        par_valid_d = 1'b0;

        if (extract) begin
            par_data_d  = word;
            par_valid_d = 1'b1;
            unique case (state_q)
                ST_SEARCH: begin
                    if (is_token) begin
                        state_d   = ST_CONFIRM;
                        tok_cnt_d = TC_W'(1);
                    end else if (word_cnt_q == WC_W'(SEARCH_WORDS - 1)) begin
                        offset_d   = next_offset(offset_q);
                        word_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + WC_W'(1);
                    end
                end
                ST_CONFIRM: begin
                    if (is_token) begin
                        tok_cnt_d = tok_cnt_q + TC_W'(1);
                        if (tok_cnt_q == TC_W'(LOCK_TOKENS - 1)) begin
                            state_d    = ST_LOCKED;
                            loss_cnt_d = '0;
                        end
                    end else begin
                        state_d    = ST_SEARCH;
                        word_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (is_token) begin
                        loss_cnt_d = '0;
                    end else if (loss_cnt_q == LC_W'(LOSS_WORDS - 1)) begin
                        state_d    = ST_SEARCH;
                        word_cnt_d = '0;
                        loss_cnt_d = '0;
                    end else begin
                        loss_cnt_d = loss_cnt_q + LC_W'(1);
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values computed above.
    always_ff @(posedge clk_5x or posedge rst) begin
        if (rst) begin
            hist_q      <= '0;
            phase_q     <= '0;
            offset_q    <= '0;
            state_q     <= ST_SEARCH;
            word_cnt_q  <= '0;
            tok_cnt_q   <= '0;
            loss_cnt_q  <= '0;
            par_data_q  <= '0;
            par_valid_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            phase_q     <= phase_d;
            offset_q    <= offset_d;
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            tok_cnt_q   <= tok_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            par_data_q  <= par_data_d;
            par_valid_q <= par_valid_d;
            locked_q    <= locked_d;
        end
    end

    assign o_par_data  = par_data_q;
    assign o_par_valid = par_valid_q;
    assign o_locked    = locked_q;
    assign o_slip_cnt  = offset_q;

endmodule
